// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: DVI control symbols, the reset symbol and the
// 8b -> 9b transition-minimising helpers used by every channel.
package tmds_pkg;

  typedef logic [9:0] tmds_sym_t;

  localparam tmds_sym_t CTRL_00 = 10'b1101010100;
  localparam tmds_sym_t CTRL_01 = 10'b0010101011;
  localparam tmds_sym_t CTRL_10 = 10'b0101010100;
  localparam tmds_sym_t CTRL_11 = 10'b1010101011;
  localparam tmds_sym_t RST_SYM = CTRL_00;

  function automatic logic [3:0] popCount8(input logic [7:0] d);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, d[i]};
    end
    return n;
  endfunction

  // Bit 8 of the result records the chosen method: 1 = XOR, 0 = XNOR.
  function automatic logic [8:0] minimizeTransitions(input logic [7:0] d);
    logic [8:0] qm;
    logic [3:0] n1;
    logic       useXnor;
    n1      = popCount8(d);
    useXnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    qm[0]   = d[0];
    for (int i = 1; i < 8; i++) begin
      qm[i] = useXnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    end
    qm[8] = ~useXnor;
    return qm;
  endfunction

  function automatic tmds_sym_t ctrlCode(input logic [1:0] ctrl);
    tmds_sym_t sym;
    unique case (ctrl)
      2'b00:   sym = CTRL_00;
      2'b01:   sym = CTRL_01;
      2'b10:   sym = CTRL_10;
      default: sym = CTRL_11;
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/tmds_channel.sv
// One TMDS channel: stage 1 registers the transition-minimised word,
// stage 2 applies DC balancing against this channel's running disparity.
module tmds_channel
  import tmds_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_d,
  input  logic [1:0] i_ctrl,
  input  logic       i_de,
  output tmds_sym_t  o_sym
);

  typedef logic signed [CNT_W-1:0] cnt_t;

  logic [8:0] w_qm;
  logic [8:0] r_qm;
  logic       r_de;
  logic [1:0] r_ctrl;

  logic [3:0] w_n1q;
  logic [3:0] w_n0q;
  cnt_t       w_n1q_ext;
  cnt_t       w_n0q_ext;
  cnt_t       w_diff;
  cnt_t       w_two_q8;
  cnt_t       w_two_nq8;
  logic       w_cnt_zero;
  logic       w_cnt_neg;
  logic       w_cnt_pos;
  logic       w_balanced;
  tmds_sym_t  w_sym_next;
  cnt_t       w_cnt_next;

  tmds_sym_t  r_sym;
  cnt_t       r_cnt;

  assign w_qm = minimizeTransitions(i_d);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_qm   <= '0;
      r_de   <= 1'b0;
      r_ctrl <= 2'b00;
    end else begin
      r_qm   <= w_qm;
      r_de   <= i_de;
      r_ctrl <= i_ctrl;
    end
  end

  assign w_n1q      = popCount8(r_qm[7:0]);
  assign w_n0q      = 4'd8 - w_n1q;
  assign w_n1q_ext  = {{(CNT_W-4){1'b0}}, w_n1q};
  assign w_n0q_ext  = {{(CNT_W-4){1'b0}}, w_n0q};
  assign w_diff     = w_n1q_ext - w_n0q_ext;
  assign w_two_q8   = {{(CNT_W-2){1'b0}}, r_qm[8], 1'b0};
  assign w_two_nq8  = {{(CNT_W-2){1'b0}}, ~r_qm[8], 1'b0};
  assign w_cnt_zero = (r_cnt == '0);
  assign w_cnt_neg  = r_cnt[CNT_W-1];
  assign w_cnt_pos  = !w_cnt_neg && !w_cnt_zero;
  assign w_balanced = (w_n1q == 4'd4);

  // w_diff is (ones - zeros); its negation is (zeros - ones).
  always_comb begin
    w_sym_next = RST_SYM;
    w_cnt_next = '0;
    if (!r_de) begin
      w_sym_next = ctrlCode(r_ctrl);
      w_cnt_next = '0;
    end else if (w_cnt_zero || w_balanced) begin
      w_sym_next = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
      w_cnt_next = r_qm[8] ? (r_cnt + w_diff) : (r_cnt - w_diff);
    end else if ((w_cnt_pos && (w_n1q > 4'd4)) || (w_cnt_neg && (w_n1q < 4'd4))) begin
      w_sym_next = {1'b1, r_qm[8], ~r_qm[7:0]};
      w_cnt_next = r_cnt + w_two_q8 - w_diff;
    end else begin
      w_sym_next = {1'b0, r_qm[8], r_qm[7:0]};
      w_cnt_next = r_cnt + w_diff - w_two_nq8;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sym <= RST_SYM;
      r_cnt <= '0;
    end else begin
      r_sym <= w_sym_next;
      r_cnt <= w_cnt_next;
    end
  end

  assign o_sym = r_sym;

endmodule

// File: rtl/tmds_encoder_dvi.sv
// Three-channel DVI TMDS encoder (blue/green/red), two-stage pipeline.
// Define TMDS_OUT_REG_EN to add a third output register stage.
module tmds_encoder_dvi
  import tmds_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic       clk_pix,
  input  logic       rst_pix_n,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       de,
  output logic [9:0] tmds_ch0,
  output logic [9:0] tmds_ch1,
  output logic [9:0] tmds_ch2
);

  tmds_sym_t w_sym0;
  tmds_sym_t w_sym1;
  tmds_sym_t w_sym2;

  tmds_channel #(.CNT_W(CNT_W)) u_ch0 (
    .i_clk   (clk_pix),
    .i_rst_n (rst_pix_n),
    .i_d     (blue),
    .i_ctrl  ({vsync, hsync}),
    .i_de    (de),
    .o_sym   (w_sym0)
  );

  tmds_channel #(.CNT_W(CNT_W)) u_ch1 (
    .i_clk   (clk_pix),
    .i_rst_n (rst_pix_n),
    .i_d     (green),
    .i_ctrl  (2'b00),
    .i_de    (de),
    .o_sym   (w_sym1)
  );

  tmds_channel #(.CNT_W(CNT_W)) u_ch2 (
    .i_clk   (clk_pix),
    .i_rst_n (rst_pix_n),
    .i_d     (red),
    .i_ctrl  (2'b00),
    .i_de    (de),
    .o_sym   (w_sym2)
  );

`ifdef TMDS_OUT_REG_EN
  tmds_sym_t r_out0;
  tmds_sym_t r_out1;
  tmds_sym_t r_out2;

  // Extra retiming stage to ease timing into the serializer.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      r_out0 <= RST_SYM;
      r_out1 <= RST_SYM;
      r_out2 <= RST_SYM;
    end else begin
      r_out0 <= w_sym0;
      r_out1 <= w_sym1;
      r_out2 <= w_sym2;
    end
  end

  assign tmds_ch0 = r_out0;
  assign tmds_ch1 = r_out1;
  assign tmds_ch2 = r_out2;
`else
  assign tmds_ch0 = w_sym0;
  assign tmds_ch1 = w_sym1;
  assign tmds_ch2 = w_sym2;
`endif

endmodule

// File: tb/tb_tmds_encoder_dvi.sv
// Scoreboard bench for tmds_encoder_dvi against a behavioural DVI encoder model.
// Honours TMDS_OUT_REG_EN for the expected pipeline latency.
module tb_tmds_encoder_dvi;

`ifdef TMDS_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam logic [9:0] RST_CODE = 10'b1101010100;

  logic       clk_pix = 1'b0;
  logic       rst_pix_n = 1'b1;
  logic [7:0] red = 8'h00;
  logic [7:0] green = 8'h00;
  logic [7:0] blue = 8'h00;
  logic       hsync = 1'b0;
  logic       vsync = 1'b0;
  logic       de = 1'b0;
  logic [9:0] tmds_ch0;
  logic [9:0] tmds_ch1;
  logic [9:0] tmds_ch2;

  typedef struct {
    logic [9:0] sym0;
    logic [9:0] sym1;
    logic [9:0] sym2;
    int         cnt0;
    int         cnt1;
    int         cnt2;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   edgeCnt = 0;
  int   checks = 0;
  int   failures = 0;
  int   mCnt0 = 0;
  int   mCnt1 = 0;
  int   mCnt2 = 0;

  tmds_encoder_dvi dut (
    .clk_pix   (clk_pix),
    .rst_pix_n (rst_pix_n),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .hsync     (hsync),
    .vsync     (vsync),
    .de        (de),
    .tmds_ch0  (tmds_ch0),
    .tmds_ch1  (tmds_ch1),
    .tmds_ch2  (tmds_ch2)
  );

  always #5 clk_pix = ~clk_pix;

  initial forever begin
    @(posedge clk_pix);
    edgeCnt++;
  end

  // Reference DVI encoder: one symbol per call, running disparity as plain ints.
  function automatic logic [9:0] refEncode(input logic [7:0] d, input logic den,
                                           input logic [1:0] ctrl, input int cntIn,
                                           output int cntOut);
    int         n1;
    int         ones;
    int         zeros;
    int         q8;
    bit         useXnor;
    logic [7:0] qm;
    logic [9:0] sym;
    if (!den) begin
      cntOut = 0;
      case (ctrl)
        2'b00:   sym = 10'b1101010100;
        2'b01:   sym = 10'b0010101011;
        2'b10:   sym = 10'b0101010100;
        default: sym = 10'b1010101011;
      endcase
      return sym;
    end
    n1      = $countones(d);
    useXnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0]   = d[0];
    for (int i = 1; i < 8; i++) begin
      qm[i] = useXnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    end
    q8    = useXnor ? 0 : 1;
    ones  = $countones(qm);
    zeros = 8 - ones;
    if (cntIn == 0 || ones == zeros) begin
      sym    = {(q8 == 0), (q8 == 1), (q8 == 1) ? qm : ~qm};
      cntOut = cntIn + ((q8 == 1) ? (ones - zeros) : (zeros - ones));
    end else if ((cntIn > 0 && ones > zeros) || (cntIn < 0 && zeros > ones)) begin
      sym    = {1'b1, (q8 == 1), ~qm};
      cntOut = cntIn + 2 * q8 + (zeros - ones);
    end else begin
      sym    = {1'b0, (q8 == 1), qm};
      cntOut = cntIn + (ones - zeros) - 2 * (1 - q8);
    end
    return sym;
  endfunction

  task automatic checkOutput(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at edge %0d: actual=%b expected=%b", name, edgeCnt, act, exp);
    end
  endtask

  task automatic checkCnt(input string name, input int act, input int exp);
    checks++;
    if (act != exp || act > 10 || act < -10) begin
      failures++;
      $display("[TB] FAIL %s at edge %0d: actual=%0d expected=%0d", name, edgeCnt, act, exp);
    end
  endtask

  // Monitor: compare whatever the scoreboard says is due after this edge.
  initial forever begin
    @(negedge clk_pix);
    if (sb.size() > 0 && sb[0].due < edgeCnt) begin
      exp_t s;
      s = sb.pop_front();
      checks++;
      failures++;
      $display("[TB] FAIL stale_entry: due=%0d now=%0d", s.due, edgeCnt);
    end else if (sb.size() > 0 && sb[0].due == edgeCnt) begin
      exp_t e;
      e = sb.pop_front();
      checkOutput("ch0", tmds_ch0, e.sym0);
      checkOutput("ch1", tmds_ch1, e.sym1);
      checkOutput("ch2", tmds_ch2, e.sym2);
`ifndef TMDS_OUT_REG_EN
      checkCnt("cnt0", int'(dut.u_ch0.r_cnt), e.cnt0);
      checkCnt("cnt1", int'(dut.u_ch1.r_cnt), e.cnt1);
      checkCnt("cnt2", int'(dut.u_ch2.r_cnt), e.cnt2);
`endif
    end
  end

  task automatic driveAndPush(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                              input logic hs, input logic vs, input logic den);
    exp_t e;
    int   c;
    red   = r;
    green = g;
    blue  = b;
    hsync = hs;
    vsync = vs;
    de    = den;
    e.sym0 = refEncode(b, den, {vs, hs}, mCnt0, c);
    mCnt0  = c;
    e.sym1 = refEncode(g, den, 2'b00, mCnt1, c);
    mCnt1  = c;
    e.sym2 = refEncode(r, den, 2'b00, mCnt2, c);
    mCnt2  = c;
    e.cnt0 = mCnt0;
    e.cnt1 = mCnt1;
    e.cnt2 = mCnt2;
    e.due  = edgeCnt + LAT;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                               input logic hs, input logic vs, input logic den);
    @(negedge clk_pix);
    driveAndPush(r, g, b, hs, vs, den);
  endtask

  task automatic applyBlank(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Reset asserted mid-cycle; outputs must switch without waiting for a clock.
  task automatic applyReset(input int hold);
    exp_t e;
    @(negedge clk_pix);
    #2;
    rst_pix_n = 1'b0;
    sb.delete();
    mCnt0 = 0;
    mCnt1 = 0;
    mCnt2 = 0;
    #1;
    checkOutput("rst_async_ch0", tmds_ch0, RST_CODE);
    checkOutput("rst_async_ch1", tmds_ch1, RST_CODE);
    checkOutput("rst_async_ch2", tmds_ch2, RST_CODE);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_pix);
      red   = 8'($urandom);
      green = 8'($urandom);
      blue  = 8'($urandom);
      hsync = 1'($urandom);
      vsync = 1'($urandom);
      de    = 1'b1;
      #1;
      checkOutput("rst_hold_ch0", tmds_ch0, RST_CODE);
      checkOutput("rst_hold_ch1", tmds_ch1, RST_CODE);
      checkOutput("rst_hold_ch2", tmds_ch2, RST_CODE);
    end
    @(negedge clk_pix);
    #2;
    rst_pix_n = 1'b1;
    for (int k = 1; k < LAT; k++) begin
      e.sym0 = RST_CODE;
      e.sym1 = RST_CODE;
      e.sym2 = RST_CODE;
      e.cnt0 = 0;
      e.cnt1 = 0;
      e.cnt2 = 0;
      e.due  = edgeCnt + k;
      sb.push_back(e);
    end
    driveAndPush(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int placed;
    int onCnt;
    $display("[TB] start, latency=%0d", LAT);
    applyReset(3);

    applyBlank(4);
    for (int c = 0; c < 4; c++) begin
      logic [1:0] cc;
      cc = 2'(c);
      applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), cc[0], cc[1], 1'b0);
    end

    applyBlank(3);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'($urandom), 8'($urandom), 8'h00, 1'b0, 1'b0, 1'b1);
    end

    applyBlank(3);
    applyStimulus(8'($urandom), 8'hFF, 8'($urandom), 1'b0, 1'b0, 1'b1);
    applyBlank(2);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b1);
    end
    applyReset(2);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b1);
    end

    for (int i = 0; i < 300; i++) begin
      applyStimulus(8'($urandom), 8'($urandom), 8'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom));
    end

    placed = 0;
    while (placed < 10000) begin
      onCnt = (10000 - placed < 640) ? (10000 - placed) : 640;
      for (int i = 0; i < onCnt; i++) begin
        applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b1);
      end
      placed += onCnt;
      for (int i = 0; i < 160; i++) begin
        applyStimulus(8'($urandom), 8'($urandom), 8'($urandom),
                      1'($urandom), 1'($urandom), 1'b0);
      end
    end

    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      @(negedge clk_pix);
    end
    #1;
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain: actual=%0d pending required=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
